// File: rtl/accel_tilt_pkg.sv
// Shared types and helpers for the tilt classifier and its abs stage.
// Holds direction codes, FSM state type and the saturating-abs function.
package accel_tilt_pkg;

    localparam logic [1:0] DIR_CENTRE = 2'b00;
    localparam logic [1:0] DIR_LEFT   = 2'b01;
    localparam logic [1:0] DIR_RIGHT  = 2'b10;

    // Widest sample the abs helper can handle (sign-extended internally).
    localparam int ABS_MAX_W = 64;

    typedef enum logic [2:0] {
        ST_CENTRE,
        ST_PEND_L,
        ST_LEFT,
        ST_PEND_R,
        ST_RIGHT,
        ST_PEND_C
    } tilt_state_e;

    // |x| for a w-bit signed value carried in ABS_MAX_W bits.
    // The most-negative w-bit value saturates to 2^(w-1)-1.
    function automatic logic [ABS_MAX_W-1:0] sat_abs(
        input logic signed [ABS_MAX_W-1:0] x,
        input int unsigned                 w
    );
        logic signed [ABS_MAX_W-1:0] lim;
        lim = ABS_MAX_W'(1) << (w - 1);
        if (x <= -lim) begin
            return lim - 1;
        end else if (x < 0) begin
            return -x;
        end else begin
            return x;
        end
    endfunction

    function automatic tilt_state_e pend_of(input logic [1:0] d);
        unique case (d)
            DIR_LEFT:  return ST_PEND_L;
            DIR_RIGHT: return ST_PEND_R;
            default:   return ST_PEND_C;
        endcase
    endfunction

    function automatic tilt_state_e commit_of(input logic [1:0] d);
        unique case (d)
            DIR_LEFT:  return ST_LEFT;
            DIR_RIGHT: return ST_RIGHT;
            default:   return ST_CENTRE;
        endcase
    endfunction

    // Direction a PEND state is waiting to commit.
    function automatic logic [1:0] pend_target(input tilt_state_e s);
        unique case (s)
            ST_PEND_L: return DIR_LEFT;
            ST_PEND_R: return DIR_RIGHT;
            default:   return DIR_CENTRE;
        endcase
    endfunction

endpackage

// File: rtl/accel_abs_sat.sv
// Registered saturating |x| stage with registered sign flags.
// Ports: clk, reset (sync, high), x in; mag, neg, pos out (1 clk late).
module accel_abs_sat
    import accel_tilt_pkg::*;
#(
    parameter int DATA_W = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] mag,
    output logic              neg,
    output logic              pos
);

    logic signed [ABS_MAX_W-1:0] x_ext;
    logic        [ABS_MAX_W-1:0] abs_w;
    logic                        unused_hi;

    always_comb begin
        x_ext = ABS_MAX_W'(signed'(x));
        abs_w = sat_abs(x_ext, DATA_W);
    end

    assign unused_hi = ^abs_w[ABS_MAX_W-1:DATA_W];

    // Sign flags travel with the magnitude so both describe one sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            mag <= '0;
            neg <= 1'b0;
            pos <= 1'b0;
        end else begin
            mag <= abs_w[DATA_W-1:0];
            neg <= x[DATA_W-1];
            pos <= !x[DATA_W-1] && (|x);
        end
    end

endmodule

// File: rtl/accel_tilt_classifier.sv
// Tilt classifier: CENTRE/LEFT/RIGHT from filtered X with hysteresis+dwell.
// Ports: clk, reset, fir_x in; tilt_dir, tilt_evt, mag_abs, pending out.
// Optional TILT_EVT_COUNT_EN adds evt_cnt_clr in and evt_cnt[15:0] out.
module accel_tilt_classifier
    import accel_tilt_pkg::*;
#(
    parameter int DATA_W       = 31,
    parameter int THRESH_HI    = 2000,
    parameter int THRESH_LO    = 1200,
    parameter int DWELL_CYCLES = 50000,
    parameter int CNT_W        = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] fir_x,
    output logic [1:0]        tilt_dir,
    output logic              tilt_evt,
    output logic [DATA_W-1:0] mag_abs,
    output logic              pending
`ifdef TILT_EVT_COUNT_EN
    ,
    input  logic              evt_cnt_clr,
    output logic [15:0]       evt_cnt
`endif
);

    localparam logic [DATA_W-1:0] THR_HI = DATA_W'(THRESH_HI);
    localparam logic [DATA_W-1:0] THR_LO = DATA_W'(THRESH_LO);
    // Counter value that, once incremented, reaches the dwell length.
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [DATA_W-1:0] x_q;
    logic [DATA_W-1:0] mag_s2;
    logic              neg_s2;
    logic              pos_s2;

    tilt_state_e       state_q;
    tilt_state_e       state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [1:0]        dir_q;
    logic [1:0]        dir_d;
    logic              evt_q;
    logic              evt_d;

    logic              want_l;
    logic              want_r;
    logic              want_c;
    logic              want_v;
    logic [1:0]        want_dir;
    logic              in_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
        end else begin
            x_q <= fir_x;
        end
    end

    accel_abs_sat #(
        .DATA_W (DATA_W)
    ) u_abs (
        .clk   (clk),
        .reset (reset),
        .x     (x_q),
        .mag   (mag_s2),
        .neg   (neg_s2),
        .pos   (pos_s2)
    );

    assign mag_abs = mag_s2;

    // Zone decode; anything between the thresholds is the hold band.
    always_comb begin
        want_l = neg_s2 && (mag_s2 >= THR_HI);
        want_r = pos_s2 && (mag_s2 >= THR_HI);
        want_c = (mag_s2 < THR_LO) || (mag_s2 == '0);
    end

    always_comb begin
        want_v   = 1'b1;
        want_dir = DIR_CENTRE;
        unique case (1'b1)
            want_l:  want_dir = DIR_LEFT;
            want_r:  want_dir = DIR_RIGHT;
            want_c:  want_dir = DIR_CENTRE;
            default: want_v   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CENTRE;
            cnt_q   <= '0;
            dir_q   <= DIR_CENTRE;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            evt_q   <= evt_d;
        end
    end

    // dir_q is always the last committed state, so it doubles as the
    // origin a PEND state falls back to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        evt_d   = 1'b0;
        in_pend = (state_q == ST_PEND_L) ||
                  (state_q == ST_PEND_R) ||
                  (state_q == ST_PEND_C);
        if (!in_pend) begin
            if (want_v && (want_dir != dir_q)) begin
                state_d = pend_of(want_dir);
                cnt_d   = CNT_W'(1);
            end
        end else if (!want_v || (want_dir == dir_q)) begin
            state_d = commit_of(dir_q);
            cnt_d   = '0;
        end else if (want_dir == pend_target(state_q)) begin
            if (cnt_q >= DWELL_LAST) begin
                state_d = commit_of(want_dir);
                dir_d   = want_dir;
                evt_d   = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            state_d = pend_of(want_dir);
            cnt_d   = CNT_W'(1);
        end
    end

    assign pending  = in_pend;
    assign tilt_dir = dir_q;
    // Masked so the pulse can never be seen while reset is asserted.
    assign tilt_evt = evt_q && !reset;

`ifdef TILT_EVT_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_cnt <= '0;
        end else if (evt_cnt_clr) begin
            evt_cnt <= '0;
        end else if (evt_q && (evt_cnt != 16'hFFFF)) begin
            evt_cnt <= evt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_accel_tilt_classifier.sv
// Self-checking bench for accel_tilt_classifier (DWELL_CYCLES=4).
// Directed table, hand sequences and random stimulus vs. a model.
module tb_accel_tilt_classifier;

    localparam int DW    = 31;
    localparam int HI    = 2000;
    localparam int LO    = 1200;
    localparam int DWELL = 4;
    localparam int NEG_MAX = -1073741824;
    localparam int POS_MAX = 1073741823;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] fir_x = '0;
    logic [1:0]    tilt_dir;
    logic          tilt_evt;
    logic [DW-1:0] mag_abs;
    logic          pending;
`ifdef TILT_EVT_COUNT_EN
    logic          evt_cnt_clr = 1'b0;
    logic [15:0]   evt_cnt;
    int            m_ecnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: signed samples in flight, committed direction
    // (0 C, 1 L, 2 R), candidate direction (-1 none) and its age.
    int m_xq, m_s2, m_dir, m_cand, m_cnt;
    bit m_evt;
    bit clr_drive = 1'b0;
    bit prev_evt = 1'b0;
    int evt_seen;

    accel_tilt_classifier #(
        .DATA_W       (DW),
        .THRESH_HI    (HI),
        .THRESH_LO    (LO),
        .DWELL_CYCLES (DWELL),
        .CNT_W        (17)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .fir_x    (fir_x),
        .tilt_dir (tilt_dir),
        .tilt_evt (tilt_evt),
        .mag_abs  (mag_abs),
        .pending  (pending)
`ifdef TILT_EVT_COUNT_EN
        ,
        .evt_cnt_clr (evt_cnt_clr),
        .evt_cnt     (evt_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic longint sat_abs_m(input int v);
        if (v == NEG_MAX) return longint'(POS_MAX);
        return (v < 0) ? -longint'(v) : longint'(v);
    endfunction

    function automatic int zone(input int v);
        longint a;
        a = sat_abs_m(v);
        if (v < 0 && a >= HI) return 1;
        if (v > 0 && a >= HI) return 2;
        if (a < LO) return 0;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task model_update(input bit r, input int x);
        int w;
        if (r) begin
            m_xq = 0; m_s2 = 0; m_dir = 0;
            m_cand = -1; m_cnt = 0; m_evt = 1'b0;
`ifdef TILT_EVT_COUNT_EN
            m_ecnt = 0;
`endif
        end else begin
            w = zone(m_s2);
`ifdef TILT_EVT_COUNT_EN
            if (clr_drive) m_ecnt = 0;
            else if (m_evt && m_ecnt < 65535) m_ecnt++;
`endif
            m_evt = 1'b0;
            if (m_cand < 0) begin
                if (w >= 0 && w != m_dir) begin
                    m_cand = w; m_cnt = 1;
                end
            end else if (w < 0 || w == m_dir) begin
                m_cand = -1; m_cnt = 0;
            end else if (w == m_cand) begin
                m_cnt++;
                if (m_cnt == DWELL) begin
                    m_dir = m_cand; m_cand = -1;
                    m_cnt = 0; m_evt = 1'b1;
                end
            end else begin
                m_cand = w; m_cnt = 1;
            end
            m_s2 = m_xq;
            m_xq = x;
        end
    endtask

    task automatic step(input bit r, input int x);
        reset = r;
        fir_x = DW'(x);
`ifdef TILT_EVT_COUNT_EN
        evt_cnt_clr = clr_drive;
`endif
        @(posedge clk);
        model_update(r, x);
        #1;
        chk("m_dir", 64'(tilt_dir), 64'(m_dir));
        chk("m_evt", 64'(tilt_evt), 64'(m_evt));
        chk("m_mag", 64'(mag_abs), 64'(sat_abs_m(m_s2)));
        chk("m_pend", 64'(pending), 64'(m_cand >= 0));
        chk("evt_consec", 64'(tilt_evt && prev_evt), 64'(0));
`ifdef TILT_EVT_COUNT_EN
        chk("m_ecnt", 64'(evt_cnt), 64'(m_ecnt));
`endif
        prev_evt = tilt_evt;
        if (tilt_evt === 1'b1) evt_seen++;
    endtask

    typedef struct {
        int         x;
        int         cycles;
        logic [1:0] dir;
        logic       evt;
        int         mag;
        logic       pend;
        int         evts;
    } vec_t;

    vec_t tbl[14];
    int   vals[17];

    initial begin
        tbl[0]  = '{5000,    6, 2'b10, 1'b1, 5000,    1'b0, 1};
        tbl[1]  = '{0,       8, 2'b00, 1'b0, 0,       1'b0, 1};
        tbl[2]  = '{-2500,   6, 2'b01, 1'b1, 2500,    1'b0, 1};
        tbl[3]  = '{-1500, 100, 2'b01, 1'b0, 1500,    1'b0, 0};
        tbl[4]  = '{-1000,   6, 2'b00, 1'b1, 1000,    1'b0, 1};
        tbl[5]  = '{2500,    3, 2'b00, 1'b0, 2500,    1'b1, 0};
        tbl[6]  = '{1500,    3, 2'b00, 1'b0, 1500,    1'b0, 0};
        tbl[7]  = '{2500,    6, 2'b10, 1'b1, 2500,    1'b0, 1};
        tbl[8]  = '{NEG_MAX, 3, 2'b10, 1'b0, POS_MAX, 1'b1, 0};
        tbl[9]  = '{NEG_MAX, 3, 2'b01, 1'b1, POS_MAX, 1'b0, 1};
        tbl[10] = '{0,       6, 2'b00, 1'b1, 0,       1'b0, 1};
        tbl[11] = '{3000,    3, 2'b00, 1'b0, 3000,    1'b1, 0};
        tbl[12] = '{-3000,   3, 2'b00, 1'b0, 3000,    1'b1, 0};
        tbl[13] = '{-3000,   3, 2'b01, 1'b1, 3000,    1'b0, 1};
        vals = '{0, 500, -500, 1199, -1199, 1200, -1200, 1500, -1500,
                 1999, -1999, 2000, -2000, 2500, -2500, NEG_MAX, POS_MAX};

        // Reset held with a large input: everything stays at zero.
        evt_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5000);
            chk("rst_dir", 64'(tilt_dir), 64'(0));
            chk("rst_evt", 64'(tilt_evt), 64'(0));
            chk("rst_mag", 64'(mag_abs), 64'(0));
            chk("rst_pend", 64'(pending), 64'(0));
        end

        for (int i = 0; i < 14; i++) begin
            evt_seen = 0;
            repeat (tbl[i].cycles) step(1'b0, tbl[i].x);
            chk($sformatf("tbl%0d_dir", i), 64'(tilt_dir), 64'(tbl[i].dir));
            chk($sformatf("tbl%0d_evt", i), 64'(tilt_evt), 64'(tbl[i].evt));
            chk($sformatf("tbl%0d_mag", i), 64'(mag_abs), 64'(tbl[i].mag));
            chk($sformatf("tbl%0d_pend", i), 64'(pending), 64'(tbl[i].pend));
            chk($sformatf("tbl%0d_evts", i), 64'(evt_seen), 64'(tbl[i].evts));
        end

        // Reset in the middle of a dwell: no event, back to CENTRE.
        evt_seen = 0;
        repeat (4) step(1'b0, 2500);
        chk("mid_pend", 64'(pending), 64'(1));
        step(1'b1, 2500);
        chk("mid_rst_pend", 64'(pending), 64'(0));
        chk("mid_rst_dir", 64'(tilt_dir), 64'(0));
        step(1'b0, 0);
        repeat (8) step(1'b0, 0);
        chk("mid_rst_evts", 64'(evt_seen), 64'(0));

`ifdef TILT_EVT_COUNT_EN
        // Clear coinciding with an event pulse wins over the increment.
        repeat (6) step(1'b0, -2500);
        chk("ec_evt_now", 64'(tilt_evt), 64'(1));
        clr_drive = 1'b1;
        step(1'b0, -2500);
        clr_drive = 1'b0;
        chk("ec_clr", 64'(evt_cnt), 64'(0));
        repeat (6) step(1'b0, 0);
        repeat (6) step(1'b0, 2500);
        repeat (6) step(1'b0, -2500);
        step(1'b0, -2500);
        chk("ec_three", 64'(evt_cnt), 64'(3));
`endif

        for (int s = 0; s < 250; s++) begin
            int x;
            int n;
            int k;
            int tmp;
            k = int'($urandom_range(19, 0));
            if (k < 17) begin
                x = vals[k];
            end else begin
                tmp = int'($urandom_range(32'h7FFF_FFFF, 0));
                x = tmp - 1073741824;
            end
            n = int'($urandom_range(8, 1));
            if ($urandom_range(39, 0) == 0) begin
                step(1'b1, x);
            end else begin
                repeat (n) step(1'b0, x);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
